// File: rtl/audio_pll_supervisor_pkg.sv
// Shared types and defaults for the audio PLL supervisor: state encoding,
// parameter defaults and the saturating relock counter helper.
package audio_pll_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_PLL_RST   = 3'd1,
    ST_WAIT_LOCK = 3'd2,
    ST_STABLE    = 3'd3,
    ST_RUN       = 3'd4,
    ST_FAIL      = 3'd5
  } pll_state_t;

  localparam int DEF_RST_CYCLES    = 16;
  localparam int DEF_LOCK_TIMEOUT  = 50000;
  localparam int DEF_STABLE_CYCLES = 1024;
  localparam int DEF_MAX_RETRIES   = 3;
  localparam int DEF_CNT_W         = 16;
  localparam int REL_CNT_W         = 8;

  function automatic logic [REL_CNT_W-1:0] sat_inc(input logic [REL_CNT_W-1:0] v);
    return (v == {REL_CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/audio_pll_supervisor_sync_2ff.sv
// Single-bit two-flop synchroniser; output lags the input by two clock edges.
module sync_2ff (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/audio_pll_supervisor.sv
// Audio PLL bring-up sequencer: resets the PLL, qualifies lock with a timeout
// and bounded retries, then releases the audio-domain reset.
// Contract: i_enable is a level request; o_ready is high exactly while in RUN
// and drops on the same edge o_audio_rst rises. No other handshake exists.
module audio_pll_supervisor
  import audio_pll_pkg::*;
#(
  parameter int RST_CYCLES    = DEF_RST_CYCLES,
  parameter int LOCK_TIMEOUT  = DEF_LOCK_TIMEOUT,
  parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int MAX_RETRIES   = DEF_MAX_RETRIES,
  parameter int CNT_W         = DEF_CNT_W
) (
  input  logic                 i_refclk,
  input  logic                 i_rst,
  input  logic                 i_enable,
  input  logic                 i_pll_locked,
  output logic                 o_pll_rst,
  output logic                 o_audio_rst,
  output logic                 o_ready,
  output logic                 o_fail,
  output logic [REL_CNT_W-1:0] o_relock_count,
  output logic [2:0]           o_state_dbg
);

  localparam int RET_W = (MAX_RETRIES < 2) ? 1 : $clog2(MAX_RETRIES + 1);

  pll_state_t           r_state;
  pll_state_t           w_state_nxt;
  logic [CNT_W-1:0]     r_timer;
  logic [CNT_W-1:0]     w_timer_nxt;
  logic [RET_W-1:0]     r_retries;
  logic [RET_W-1:0]     w_retries_nxt;
  logic [RET_W-1:0]     w_retries_inc;
  logic [REL_CNT_W-1:0] r_relock;
  logic [REL_CNT_W-1:0] w_relock_nxt;
  logic                 r_pll_rst;
  logic                 r_audio_rst;
  logic                 r_ready;
  logic                 r_fail;
  logic                 w_locked_s;

  sync_2ff u_lock_sync (
    .i_clk (i_refclk),
    .i_rst (i_rst),
    .i_d   (i_pll_locked),
    .o_q   (w_locked_s)
  );

  assign w_retries_inc = r_retries + 1'b1;

  always_comb begin
    w_state_nxt   = r_state;
    w_timer_nxt   = r_timer;
    w_retries_nxt = r_retries;
    w_relock_nxt  = r_relock;
    if (!i_enable) begin
      w_state_nxt   = ST_IDLE;
      w_timer_nxt   = '0;
      w_retries_nxt = '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          w_state_nxt = ST_PLL_RST;
          w_timer_nxt = '0;
        end
        ST_PLL_RST: begin
          if (r_timer == CNT_W'(RST_CYCLES - 1)) begin
            w_state_nxt = ST_WAIT_LOCK;
            w_timer_nxt = '0;
          end else begin
            w_timer_nxt = r_timer + 1'b1;
          end
        end
        ST_WAIT_LOCK: begin
          // Lock wins over a timeout landing on the same cycle.
          if (w_locked_s) begin
            w_state_nxt = ST_STABLE;
            w_timer_nxt = '0;
          end else if (r_timer == CNT_W'(LOCK_TIMEOUT - 1)) begin
            w_retries_nxt = w_retries_inc;
            w_timer_nxt   = '0;
            w_state_nxt   = (w_retries_inc == RET_W'(MAX_RETRIES)) ? ST_FAIL : ST_PLL_RST;
          end else begin
            w_timer_nxt = r_timer + 1'b1;
          end
        end
        ST_STABLE: begin
          if (!w_locked_s) begin
            w_state_nxt = ST_WAIT_LOCK;
            w_timer_nxt = '0;
          end else if (r_timer == CNT_W'(STABLE_CYCLES - 1)) begin
            w_state_nxt   = ST_RUN;
            w_timer_nxt   = '0;
            w_retries_nxt = '0;
          end else begin
            w_timer_nxt = r_timer + 1'b1;
          end
        end
        ST_RUN: begin
          if (!w_locked_s) begin
            w_state_nxt  = ST_PLL_RST;
            w_timer_nxt  = '0;
            w_relock_nxt = sat_inc(r_relock);
          end
        end
        ST_FAIL: begin
          w_state_nxt = ST_FAIL;
        end
        default: begin
          w_state_nxt = ST_IDLE;
          w_timer_nxt = '0;
        end
      endcase
    end
  end

  always_ff @(posedge i_refclk) begin
    if (i_rst) begin
      r_state     <= ST_IDLE;
      r_timer     <= '0;
      r_retries   <= '0;
      r_relock    <= '0;
      r_pll_rst   <= 1'b1;
      r_audio_rst <= 1'b1;
      r_ready     <= 1'b0;
      r_fail      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_timer     <= w_timer_nxt;
      r_retries   <= w_retries_nxt;
      r_relock    <= w_relock_nxt;
      // Outputs decode the next state so they move with the state register.
      r_pll_rst   <= (w_state_nxt == ST_IDLE) || (w_state_nxt == ST_PLL_RST) ||
                     (w_state_nxt == ST_FAIL);
      r_audio_rst <= (w_state_nxt != ST_RUN);
      r_ready     <= (w_state_nxt == ST_RUN);
      r_fail      <= (w_state_nxt == ST_FAIL);
    end
  end

  assign o_pll_rst      = r_pll_rst;
  assign o_audio_rst    = r_audio_rst;
  assign o_ready        = r_ready;
  assign o_fail         = r_fail;
  assign o_relock_count = r_relock;
  assign o_state_dbg    = r_state;

endmodule

// File: doc/audio_pll_supervisor.md
Name: audio_pll_supervisor

Overview:
- Sequences the audio-clock PLL (50 MHz refclk in, 12.288 MHz audio clock out).
- Drives the PLL reset, waits for a stable lock with a timeout and bounded retries, then releases the audio-domain reset and reports ready.
- On lock loss during operation, re-asserts the audio reset and re-runs the PLL bring-up.
- Sits beside the PLL wrapper at system top level and runs on the 50 MHz reference clock.

Parameters:
- RST_CYCLES, 16: cycles pll_rst is held high per bring-up attempt (minimum 1).
- LOCK_TIMEOUT, 50000: cycles allowed in WAIT_LOCK before an attempt fails (1 ms at 50 MHz).
- STABLE_CYCLES, 1024: consecutive locked cycles required before RUN.
- MAX_RETRIES, 3: failed attempts tolerated before FAIL (minimum 1).
- CNT_W, 16: timer width; must satisfy 2^CNT_W > max(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES).

Ports:
- refclk, in, 1: 50 MHz clock; the only clock in the block.
- rst, in, 1: synchronous, active-high reset.
- enable, in, 1: start or keep the PLL running; low forces IDLE.
- pll_locked, in, 1: PLL locked output; asynchronous, synchronised internally.
- pll_rst, out, 1: reset to the PLL.
- audio_rst, out, 1: reset for audio-domain logic; high in every state except RUN.
- ready, out, 1: high only in RUN.
- fail, out, 1: high only in FAIL.
- relock_count, out, 8: count of lock losses seen in RUN; saturates at 255.
- state_dbg, out, 3: current state encoding.

Behaviour:
- Reset values (rst=1 on a refclk edge):
  - state=IDLE, pll_rst=1, audio_rst=1, ready=0, fail=0, relock_count=0, retries=0, timer=0.
  - Synchroniser flops reset to 0.
- pll_locked passes through a 2-flop synchroniser; locked_s lags the input by 2 edges.
- Outputs are registered and decoded from next-state, so each output changes on the same edge as the state register.
- enable=0 has priority in every state: next state is IDLE, and retries is cleared.
- States and transitions:
  - IDLE: pll_rst=1. On enable=1, go to PLL_RST with timer=0.
  - PLL_RST: pll_rst=1. Stay for exactly RST_CYCLES cycles, then go to WAIT_LOCK with timer=0.
  - WAIT_LOCK: pll_rst=0, timer counts up.
    - locked_s=1: go to STABLE with timer=0. Lock takes priority over a same-cycle timeout.
    - timer==LOCK_TIMEOUT-1 with locked_s=0: retries+1. If the new retries==MAX_RETRIES, go to FAIL; otherwise go to PLL_RST.
  - STABLE: pll_rst=0, timer counts consecutive cycles with locked_s=1.
    - locked_s=0: go to WAIT_LOCK with timer=0; retries unchanged.
    - locked_s=1 with timer==STABLE_CYCLES-1: go to RUN and clear retries.
  - RUN: audio_rst=0, ready=1.
    - locked_s=0: relock_count+1 (saturating), then go to PLL_RST.
    - audio_rst=1 and ready=0 on that same edge.
  - FAIL: pll_rst=1, fail=1. Held until enable=0, then IDLE.
- Latency: pll_locked sampled high at edge k gives STABLE at edge k+2 and RUN at edge k+2+STABLE_CYCLES.
- A glitch on locked shorter than one cycle may be missed; this is accepted.
- rst mid-operation: all state returns to reset values on that edge, including relock_count.
- enable held low keeps the PLL permanently in reset.

Decomposition:
- Package audio_pll_pkg holds:
  - state type with encodings IDLE=0, PLL_RST=1, WAIT_LOCK=2, STABLE=3, RUN=4, FAIL=5;
  - default parameter constants;
  - REL_CNT_W=8.
- One sub-module, sync_2ff: a 1-bit two-flop synchroniser with synchronous reset-to-0, instantiated for pll_locked.

Test Plan:
Test parameters: RST_CYCLES=4, LOCK_TIMEOUT=20, STABLE_CYCLES=8, MAX_RETRIES=2.
- Nominal bring-up: enable=1 at cycle 0, model asserts pll_locked 5 cycles after pll_rst falls.
  - Required: pll_rst high for exactly 4 cycles.
  - Required: ready=1 and audio_rst=0 exactly 10 edges after pll_locked is first sampled high.
- Stability glitch: pll_locked drops for 3 cycles while in STABLE.
  - Required: return to WAIT_LOCK, then full 8-cycle qualification again; ready delayed accordingly.
  - Required: retries unchanged; pll_rst not re-asserted.
- Lock loss in RUN: deassert pll_locked.
  - Required: audio_rst=1 and ready=0 within 3 edges; relock_count 0→1; pll_rst pulses 4 cycles.
  - Required: RUN regained after relock.
- Retry exhaustion: pll_locked held 0.
  - Required: two 4-cycle pll_rst pulses, each followed by 20 WAIT_LOCK cycles, then fail=1 with pll_rst=1.
  - Required: enable=0 returns to IDLE with fail=0; enable=1 restarts bring-up.
- Reset and saturation: force 256 lock losses, expect relock_count=255. Assert rst in RUN.
  - Required: next edge gives pll_rst=1, audio_rst=1, ready=0, relock_count=0, state_dbg=0.
- Timeout/lock coincidence: pll_locked rises so locked_s=1 on the same cycle the timer hits 19.
  - Required: enter STABLE, no retry counted.
